// File: rtl/dcache_dm.sv
// dcache_dm: direct-mapped data cache, one 32-bit word per line, between MEM stage and data RAM.
// Build option: define DCACHE_WRITE_BACK_EN for write-back/write-allocate; default is write-through/no-allocate.
module dcache_dm #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_data_ready
);

  // state | meaning
  // IDLE  | serve hits, decide what a miss or write-through needs
  // FILL  | read the requested line from RAM
  // WTHRU | write the held store through to RAM
  // EVICT | write the dirty victim line back to RAM (write-back build only)

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WTHRU = 2'd2,
    EVICT = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
`ifdef DCACHE_WRITE_BACK_EN
  logic [LINES-1:0] dirty;
  logic             dirty_set, dirty_clr;
`endif

  // done keeps a finished write-through from re-firing while the pipeline still holds it
  logic done, done_nxt;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [31:0]        line_data, merged;
  logic               hit, act, rdy, wt_store;
  logic               line_fill, line_merge;

  logic        ram_ce_nxt, ram_we_nxt;
  logic [31:0] ram_addr_nxt, ram_data_nxt;
  logic [3:0]  ram_sel_nxt;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  assign req_tag   = mem_addr_i[31:INDEX_W+2];
  assign req_idx   = mem_addr_i[INDEX_W+1:2];
  assign line_data = data_mem[req_idx];
  assign hit       = mem_ce_i & valid[req_idx] & (tag_mem[req_idx] == req_tag);
  assign act       = mem_ce_i & ~done;
  assign rdy       = ram_data_ready & ram_ce_o;

`ifdef DCACHE_WRITE_BACK_EN
  assign wt_store = 1'b0;
`else
  assign wt_store = mem_we_i;
`endif

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = mem_sel_i[b] ? mem_data_i[8*b +: 8] : line_data[8*b +: 8];
    end
  end

  assign stallreq   = ~rst & ((state != IDLE) | (act & (~hit | wt_store)));
  assign mem_data_o = (~rst && state == IDLE && hit && !mem_we_i) ? line_data : 32'h0;

  always_comb begin
    state_nxt    = state;
    done_nxt     = done;
    ram_ce_nxt   = ram_ce_o;
    ram_we_nxt   = ram_we_o;
    ram_addr_nxt = ram_addr_o;
    ram_sel_nxt  = ram_sel_o;
    ram_data_nxt = ram_data_o;
    line_fill    = 1'b0;
    line_merge   = 1'b0;
`ifdef DCACHE_WRITE_BACK_EN
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
`endif
    case (state)
      IDLE: begin
        done_nxt = 1'b0;
        if (act && hit && mem_we_i) begin
          line_merge = 1'b1;
`ifdef DCACHE_WRITE_BACK_EN
          dirty_set  = 1'b1;
`else
          state_nxt    = WTHRU;
          ram_ce_nxt   = 1'b1;
          ram_we_nxt   = 1'b1;
          ram_addr_nxt = {mem_addr_i[31:2], 2'b00};
          ram_sel_nxt  = mem_sel_i;
          ram_data_nxt = mem_data_i;
`endif
        end else if (act && !hit) begin
`ifdef DCACHE_WRITE_BACK_EN
          if (valid[req_idx] && dirty[req_idx]) begin
            state_nxt    = EVICT;
            ram_ce_nxt   = 1'b1;
            ram_we_nxt   = 1'b1;
            ram_addr_nxt = {tag_mem[req_idx], req_idx, 2'b00};
            ram_sel_nxt  = 4'b1111;
            ram_data_nxt = line_data;
          end else begin
            state_nxt    = FILL;
            ram_ce_nxt   = 1'b1;
            ram_we_nxt   = 1'b0;
            ram_addr_nxt = {mem_addr_i[31:2], 2'b00};
            ram_sel_nxt  = 4'b1111;
            ram_data_nxt = 32'h0;
          end
`else
          // no-write-allocate: a store miss goes straight to RAM
          state_nxt    = mem_we_i ? WTHRU : FILL;
          ram_ce_nxt   = 1'b1;
          ram_we_nxt   = mem_we_i;
          ram_addr_nxt = {mem_addr_i[31:2], 2'b00};
          ram_sel_nxt  = mem_we_i ? mem_sel_i : 4'b1111;
          ram_data_nxt = mem_we_i ? mem_data_i : 32'h0;
`endif
        end
      end
`ifdef DCACHE_WRITE_BACK_EN
      EVICT: begin
        if (rdy) begin
          dirty_clr    = 1'b1;
          state_nxt    = FILL;
          ram_ce_nxt   = 1'b1;
          ram_we_nxt   = 1'b0;
          ram_addr_nxt = {mem_addr_i[31:2], 2'b00};
          ram_sel_nxt  = 4'b1111;
          ram_data_nxt = 32'h0;
        end
      end
`endif
      FILL: begin
        if (rdy) begin
          line_fill    = 1'b1;
          state_nxt    = IDLE;
          ram_ce_nxt   = 1'b0;
          ram_we_nxt   = 1'b0;
          ram_addr_nxt = 32'h0;
          ram_sel_nxt  = 4'b0000;
          ram_data_nxt = 32'h0;
        end
      end
      WTHRU: begin
        if (rdy) begin
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
          ram_ce_nxt   = 1'b0;
          ram_we_nxt   = 1'b0;
          ram_addr_nxt = 32'h0;
          ram_sel_nxt  = 4'b0000;
          ram_data_nxt = 32'h0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        ram_ce_nxt   = 1'b0;
        ram_we_nxt   = 1'b0;
        ram_addr_nxt = 32'h0;
        ram_sel_nxt  = 4'b0000;
        ram_data_nxt = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      done       <= 1'b0;
      valid      <= '0;
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= 32'h0;
      ram_sel_o  <= 4'b0000;
      ram_data_o <= 32'h0;
    end else begin
      state      <= state_nxt;
      done       <= done_nxt;
      ram_ce_o   <= ram_ce_nxt;
      ram_we_o   <= ram_we_nxt;
      ram_addr_o <= ram_addr_nxt;
      ram_sel_o  <= ram_sel_nxt;
      ram_data_o <= ram_data_nxt;
      if (line_fill) valid[req_idx] <= 1'b1;
    end
  end

`ifdef DCACHE_WRITE_BACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty <= '0;
    end else if (line_fill || dirty_clr) begin
      dirty[req_idx] <= 1'b0;
    end else if (dirty_set) begin
      dirty[req_idx] <= 1'b1;
    end
  end
`endif

  // tag/data arrays carry no reset; valid alone decides whether a line is usable
  always_ff @(posedge clk) begin
    if (line_fill) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= ram_data_i;
    end else if (line_merge) begin
      data_mem[req_idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Self-checking bench for dcache_dm: latency-programmable RAM responder with a transaction scoreboard.
`timescale 1ns/1ps
module tb_dcache_dm;

  logic        clk;
  logic        rst;
  logic        mem_ce_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [3:0]  mem_sel_i;
  logic        stallreq;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;
  logic        ram_data_ready, resp_ready, inject_ready;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } ram_txn_t;

  ram_txn_t    exp_q[$];
  ram_txn_t    mon_txn;
  logic [31:0] ram_mem [logic [31:0]];
  int          ram_lat = 3;
  int          resp_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] b2b_data [4];
  logic [31:0] reload_addr, reload_data;

  assign ram_data_ready = resp_ready | inject_ready;

  dcache_dm #(.INDEX_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_ce_i       (mem_ce_i),
    .mem_we_i       (mem_we_i),
    .mem_addr_i     (mem_addr_i),
    .mem_sel_i      (mem_sel_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .stallreq       (stallreq),
    .ram_ce_o       (ram_ce_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_sel_o      (ram_sel_o),
    .ram_data_o     (ram_data_o),
    .ram_data_i     (ram_data_i),
    .ram_data_ready (ram_data_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input logic we, input logic [31:0] addr,
                                   input logic [3:0] sel, input logic [31:0] data);
    ram_txn_t t;
    t.we = we; t.addr = addr; t.sel = sel; t.data = data;
    exp_q.push_back(t);
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // RAM responder: ready pulses ram_lat cycles after ram_ce_o rises; each completion is scored
  initial begin
    resp_ready = 1'b0;
    ram_data_i = 32'h0;
    resp_cnt   = 0;
    forever begin
      @(negedge clk);
      if (resp_ready) begin
        resp_ready = 1'b0;
        resp_cnt   = ram_ce_o ? 1 : 0;
      end else if (ram_ce_o) begin
        if (resp_cnt >= ram_lat) begin
          resp_ready = 1'b1;
          resp_cnt   = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ram_unexpected we=%0b addr=%h sel=%b data=%h",
                     ram_we_o, ram_addr_o, ram_sel_o, ram_data_o);
          end else begin
            mon_txn = exp_q.pop_front();
            if (ram_we_o !== mon_txn.we || ram_addr_o !== mon_txn.addr || ram_sel_o !== mon_txn.sel ||
                (mon_txn.we && ram_data_o !== mon_txn.data)) begin
              errors++;
              $display("FAIL ram_txn got we=%0b addr=%h sel=%b data=%h want we=%0b addr=%h sel=%b data=%h",
                       ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
                       mon_txn.we, mon_txn.addr, mon_txn.sel, mon_txn.data);
            end
          end
          if (ram_we_o) begin
            ram_mem[ram_addr_o] = lane_merge(ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : 32'h0,
                                             ram_data_o, ram_sel_o);
            ram_data_i = 32'h0;
          end else begin
            ram_data_i = ram_mem.exists(ram_addr_o) ? ram_mem[ram_addr_o] : 32'h0;
          end
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, output int stalls, output logic [31:0] rdata);
    int n;
    bit fin;
    n = 0; fin = 1'b0; rdata = 32'h0;
    @(posedge clk); #1;
    mem_ce_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_sel_i = sel; mem_data_i = wdata;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (stallreq) begin
        n++;
        @(posedge clk); #1;
      end else begin
        rdata = mem_data_o;
        fin = 1'b1;
      end
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL access_timeout addr=%h stall still high after 200 cycles", addr);
    end
    @(posedge clk); #1;
    mem_ce_i = 1'b0; mem_we_i = 1'b0;
    stalls = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_sel_i = 4'h0; mem_data_i = 32'h0;
    inject_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stallreq, ram_ce_o, ram_we_o} !== 3'b000 || mem_data_o !== 32'h0 || ram_addr_o !== 32'h0 ||
        ram_sel_o !== 4'h0 || ram_data_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs stall=%b ce=%b we=%b addr=%h sel=%b wdata=%h rdata=%h required all zero",
               stallreq, ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o, mem_data_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0 || ram_ce_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release stall=%b ce=%b required 0 0", stallreq, ram_ce_o);
    end
  endtask

  task automatic test_read_miss();
    int st;
    logic [31:0] rd;
    ram_lat = 3;
    ram_mem[32'h100] = 32'hDEADBEEF;
    push_exp(1'b0, 32'h100, 4'hF, 32'h0);
    access(1'b0, 32'h100, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== 5) begin errors++; $display("FAIL miss_stall got %0d required 5", st); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data got %h required deadbeef", rd); end
    access(1'b0, 32'h100, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== 0 || rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reload_hit stall=%0d data=%h required 0 deadbeef", st, rd);
    end
  endtask

  task automatic test_store_hit();
    int st, exp_st;
    logic [31:0] rd;
`ifdef DCACHE_WRITE_BACK_EN
    exp_st = 0;
`else
    exp_st = ram_lat + 2;
    push_exp(1'b1, 32'h100, 4'b0011, 32'h0000ABCD);
`endif
    access(1'b1, 32'h100, 4'b0011, 32'h0000ABCD, st, rd);
    checks++;
    if (st !== exp_st) begin errors++; $display("FAIL store_hit_stall got %0d required %0d", st, exp_st); end
    access(1'b0, 32'h100, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== 0 || rd !== 32'hDEADABCD) begin
      errors++; $display("FAIL store_hit_reload stall=%0d data=%h required 0 deadabcd", st, rd);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL store_hit_ram pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_miss_replace();
    int st, exp_st;
    logic [31:0] rd;
`ifdef DCACHE_WRITE_BACK_EN
    ram_mem[32'h200] = 32'h12345678;
    push_exp(1'b1, 32'h100, 4'hF, 32'hDEADABCD);
    push_exp(1'b0, 32'h200, 4'hF, 32'h0);
    exp_st = 2 * ram_lat + 3;
    reload_addr = 32'h200;
    reload_data = 32'h12345678;
`else
    push_exp(1'b1, 32'h300, 4'hF, 32'hCAFEF00D);
    access(1'b1, 32'h300, 4'hF, 32'hCAFEF00D, st, rd);
    checks++;
    if (st !== ram_lat + 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL wt_store_miss stall=%0d pending=%0d required %0d 0", st, exp_q.size(), ram_lat + 2);
    end
    push_exp(1'b0, 32'h300, 4'hF, 32'h0);
    exp_st = ram_lat + 2;
    reload_addr = 32'h300;
    reload_data = 32'hCAFEF00D;
`endif
    access(1'b0, reload_addr, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== exp_st || rd !== reload_data) begin
      errors++; $display("FAIL replace_load stall=%0d data=%h required %0d %h", st, rd, exp_st, reload_data);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL replace_ram pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int st;
    logic [31:0] rd;
    @(posedge clk); #1;
    mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h140; mem_sel_i = 4'hF;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ram_ce_o !== 1'b1 || ram_we_o !== 1'b0 || ram_addr_o !== 32'h140 || stallreq !== 1'b1) begin
      errors++; $display("FAIL fill_start ce=%b we=%b addr=%h stall=%b required 1 0 00000140 1",
                         ram_ce_o, ram_we_o, ram_addr_o, stallreq);
    end
    @(posedge clk); #1;
    rst = 1'b1; mem_ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_ce_o !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL reset_mid_fill ce=%b stall=%b required 0 0", ram_ce_o, stallreq);
    end
    push_exp(1'b0, reload_addr, 4'hF, 32'h0);
    access(1'b0, reload_addr, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== ram_lat + 2 || rd !== reload_data) begin
      errors++; $display("FAIL post_reset_reload stall=%0d data=%h required %0d %h", st, rd, ram_lat + 2, reload_data);
    end
  endtask

  task automatic test_spurious_ready();
    int st;
    logic [31:0] rd;
    @(posedge clk); #1;
    inject_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ram_ce_o !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL spurious_during ce=%b stall=%b required 0 0", ram_ce_o, stallreq);
    end
    @(posedge clk); #1;
    inject_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ram_ce_o !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL spurious_after ce=%b stall=%b required 0 0", ram_ce_o, stallreq);
    end
    access(1'b0, reload_addr, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== 0 || rd !== reload_data) begin
      errors++; $display("FAIL spurious_reload stall=%0d data=%h required 0 %h", st, rd, reload_data);
    end
  endtask

  task automatic test_back_to_back();
    int st;
    logic [31:0] rd, a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h400 + 32'(4 * i);
      b2b_data[i] = $urandom;
      ram_mem[a] = b2b_data[i];
      ram_lat = i + 1;
      push_exp(1'b0, a, 4'hF, 32'h0);
      access(1'b0, a, 4'hF, 32'h0, st, rd);
      checks++;
      if (st !== i + 3 || rd !== b2b_data[i]) begin
        errors++; $display("FAIL b2b_miss[%0d] stall=%0d data=%h required %0d %h", i, st, rd, i + 3, b2b_data[i]);
      end
    end
    ram_lat = 3;
    for (int i = 0; i < 4; i++) begin
      a = 32'h400 + 32'(4 * i);
      access(1'b0, a, 4'hF, 32'h0, st, rd);
      checks++;
      if (st !== 0 || rd !== b2b_data[i]) begin
        errors++; $display("FAIL b2b_hit[%0d] stall=%0d data=%h required 0 %h", i, st, rd, b2b_data[i]);
      end
    end
  endtask

  task automatic test_byte_lanes();
    int st, exp_st;
    logic [31:0] rd, want;
    want = lane_merge(b2b_data[1], 32'hFFEEDDCC, 4'b1010);
`ifdef DCACHE_WRITE_BACK_EN
    exp_st = 0;
`else
    exp_st = ram_lat + 2;
    push_exp(1'b1, 32'h404, 4'b1010, 32'hFFEEDDCC);
`endif
    access(1'b1, 32'h404, 4'b1010, 32'hFFEEDDCC, st, rd);
    checks++;
    if (st !== exp_st) begin errors++; $display("FAIL lanes_stall got %0d required %0d", st, exp_st); end
    access(1'b0, 32'h404, 4'hF, 32'h0, st, rd);
    checks++;
    if (st !== 0 || rd !== want) begin
      errors++; $display("FAIL lanes_reload stall=%0d data=%h required 0 %h", st, rd, want);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lanes_ram pending=%0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_store_hit();
    test_miss_replace();
    test_reset_mid_fill();
    test_spurious_ready();
    test_back_to_back();
    test_byte_lanes();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
